// File: rtl/dtimer16_pkg.sv
// Shared constants and state encoding for the dtimer16 down-counting reload timer.
package dtimer16_pkg;

  localparam int              SIZE        = 16;
  localparam logic [SIZE-1:0] DEFAULT_VAL = 16'h00FC;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/dtimer16_if.sv
// Control/status bundle of dtimer16; the timer is the slave, its driver the master.
interface dtimer16_if #(
  parameter int SIZE = 16
) ();

  logic            _load;
  logic [SIZE-1:0] preld_val;
  logic            _start;
  logic            _stop;
  logic            _mode;
  logic            _enable;
  logic [SIZE-1:0] dcount;
  logic            tick;
  logic            busy;
  logic            done;

  modport master (
    output _load, preld_val, _start, _stop, _mode, _enable,
    input  dcount, tick, busy, done
  );

  modport slave (
    input  _load, preld_val, _start, _stop, _mode, _enable,
    output dcount, tick, busy, done
  );

endinterface

// File: rtl/dtimer16_prescale.sv
// Enabled-cycle prescaler: step pulses on every PRESCALE-th enabled cycle.
module dtimer16_prescale #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic _sreset,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int           W    = $clog2(PRESCALE);
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (_sreset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign step = en && (cnt_q == LAST);

endmodule

// File: rtl/dtimer16.sv
// 16-bit down-counting reload timer with one-shot / periodic modes and a one-cycle tick.
// Optional prescaler enabled by defining PRESCALE_EN.
module dtimer16 #(
  parameter int                   SIZE        = dtimer16_pkg::SIZE,
  parameter logic [SIZE-1:0]      DEFAULT_VAL = dtimer16_pkg::DEFAULT_VAL
`ifdef PRESCALE_EN
  , parameter int                 PRESCALE    = 4
`endif
) (
  input  logic        clk,
  input  logic        _sreset,
  dtimer16_if.slave   bus
);

  import dtimer16_pkg::*;

  state_e          state_q, state_d;
  logic [SIZE-1:0] dcount_q, dcount_d;
  logic [SIZE-1:0] reload_q, reload_d;
  logic            tick_q, tick_d;
  logic            step;
  logic            reload_nz;

  assign reload_nz = (reload_q != '0);

`ifdef PRESCALE_EN
  logic ps_clr;

  // Prescaler phase restarts on any (re)start or stop, and sits at 0 outside RUN.
  assign ps_clr = (state_q != RUN) || bus._start || bus._stop;

  dtimer16_prescale #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .clk     (clk),
    ._sreset (_sreset),
    .clr     (ps_clr),
    .en      (bus._enable),
    .step    (step)
  );
`else
  assign step = bus._enable;
`endif

  always_ff @(posedge clk) begin
    if (_sreset) begin
      state_q  <= IDLE;
      dcount_q <= '0;
      reload_q <= DEFAULT_VAL;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcount_q <= dcount_d;
      reload_q <= reload_d;
      tick_q   <= tick_d;
    end
  end

  // Transitions read reload_q, so a same-cycle _load only affects later starts.
  always_comb begin
    state_d  = state_q;
    dcount_d = dcount_q;
    tick_d   = 1'b0;
    reload_d = bus._load ? bus.preld_val : reload_q;
    unique case (state_q)
      IDLE: begin
        if (bus._start && reload_nz) begin
          state_d  = RUN;
          dcount_d = reload_q;
        end
      end
      RUN: begin
        if (bus._stop) begin
          state_d  = IDLE;
          dcount_d = '0;
        end else if (bus._start) begin
          // A zero reload would park RUN at 0 forever; fall back to IDLE.
          if (reload_nz) begin
            dcount_d = reload_q;
          end else begin
            state_d  = IDLE;
            dcount_d = '0;
          end
        end else if (step) begin
          if (dcount_q > SIZE'(1)) begin
            dcount_d = dcount_q - 1'b1;
          end else if (dcount_q == SIZE'(1)) begin
            tick_d = 1'b1;
            if (bus._mode && reload_nz) begin
              dcount_d = reload_q;
            end else begin
              dcount_d = '0;
              state_d  = bus._mode ? IDLE : DONE;
            end
          end
        end
      end
      DONE: begin
        if (bus._stop) begin
          state_d = IDLE;
        end else if (bus._start && reload_nz) begin
          state_d  = RUN;
          dcount_d = reload_q;
        end
      end
      default: begin
        state_d  = IDLE;
        dcount_d = '0;
      end
    endcase
  end

  always_comb begin
    bus.dcount = dcount_q;
    bus.tick   = tick_q;
    bus.busy   = (state_q == RUN);
    bus.done   = (state_q == DONE);
  end

endmodule

// File: tb/tb_dtimer16.sv
// Scoreboard bench for dtimer16: driver pushes model predictions, monitor pops and compares.
module tb_dtimer16;

`ifdef PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  typedef struct {
    logic [15:0] dcount;
    logic        tick;
    logic        busy;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic sreset;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state: phase 0=idle 1=running 2=expired
  int m_phase, m_cnt, m_reload, m_ps;
  bit m_tick;

  dtimer16_if #(.SIZE(16)) bus ();

  dtimer16 dut (
    .clk     (clk),
    ._sreset (sreset),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic model(input bit rst, input bit ld, input int val, input bit st,
                       input bit sp, input bit md, input bit en);
    bit step;
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_reload = 'hFC; m_ps = 0; m_tick = 0;
      return;
    end
    step = en && (m_ps == PS - 1);
    if (m_phase != 1 || st || sp) m_ps = 0;
    else if (en)                  m_ps = (m_ps + 1) % PS;
    m_tick = 0;
    if (m_phase == 0) begin
      if (st && m_reload != 0) begin m_phase = 1; m_cnt = m_reload; end
    end else if (m_phase == 2) begin
      if (sp) m_phase = 0;
      else if (st && m_reload != 0) begin m_phase = 1; m_cnt = m_reload; end
    end else begin
      if (sp) begin
        m_phase = 0; m_cnt = 0;
      end else if (st) begin
        if (m_reload != 0) m_cnt = m_reload;
        else begin m_phase = 0; m_cnt = 0; end
      end else if (step) begin
        if (m_cnt > 1) m_cnt = m_cnt - 1;
        else begin
          m_tick = 1;
          if (md && m_reload != 0) m_cnt = m_reload;
          else begin m_cnt = 0; m_phase = md ? 0 : 2; end
        end
      end
    end
    if (ld) m_reload = val;
  endtask

  // Apply one cycle of inputs, predict the post-edge outputs, advance to next negedge.
  task automatic cyc(input bit rst, input bit ld, input int val, input bit st,
                     input bit sp, input bit md, input bit en);
    exp_t e;
    sreset        = rst;
    bus._load     = ld;
    bus.preld_val = 16'(val);
    bus._start    = st;
    bus._stop     = sp;
    bus._mode     = md;
    bus._enable   = en;
    model(rst, ld, val, st, sp, md, en);
    e.dcount = 16'(m_cnt);
    e.tick   = m_tick;
    e.busy   = (m_phase == 1);
    e.done   = (m_phase == 2);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit md, input bit en);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, md, en);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.dcount !== e.dcount || bus.tick !== e.tick ||
            bus.busy !== e.busy || bus.done !== e.done) begin
          n_fail++;
          $display("FAIL outputs @%0t: got dcount=%0d tick=%b busy=%b done=%b, want dcount=%0d tick=%b busy=%b done=%b",
                   $time, bus.dcount, bus.tick, bus.busy, bus.done,
                   e.dcount, e.tick, e.busy, e.done);
        end
      end
    end
  end

  initial begin : driver
    // Reset, then a start from the default reload (252 steps to tick)
    cyc(1, 0, 0, 0, 0, 0, 1);
    run(2, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 1);
    run(252 * PS + 4, 0, 1);
    // One-shot from 5, done holds
    cyc(0, 1, 5, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 1);
    run(5 * PS + 4, 0, 1);
    // Periodic 3, then reload 2 mid-run
    cyc(0, 1, 3, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0, 1, 1);
    run(10 * PS, 1, 1);
    cyc(0, 1, 2, 0, 0, 1, 1);
    run(8 * PS, 1, 1);
    cyc(0, 0, 0, 0, 1, 1, 1);
    // Hold at 4 with enable low, then start+stop together
    cyc(0, 1, 6, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 1);
    run(2 * PS, 0, 1);
    run(3, 0, 0);
    cyc(0, 0, 0, 1, 1, 0, 1);
    run(2, 0, 1);
    // Zero reload ignored; reset mid-run at 7
    cyc(0, 1, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 1);
    run(3, 0, 1);
    cyc(0, 1, 10, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 1);
    run(3 * PS, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 1);
    run(2, 0, 1);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit rst, ld, st, sp, md, en;
      int val;
      rst = ($urandom_range(0, 399) == 0);
      ld  = ($urandom_range(0, 29) == 0);
      val = $urandom_range(1, 12);
      st  = ($urandom_range(0, 39) == 0);
      sp  = ($urandom_range(0, 89) == 0);
      md  = ($urandom_range(0, 3) != 0);
      en  = ($urandom_range(0, 9) != 0);
      cyc(rst, ld, val, st, sp, md, en);
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected outputs never compared, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dtimer16.md
Name: dtimer16

Overview:
16-bit down-counting reload timer. It is the count-down companion of the up/down event counter: it loads a period value, decrements to terminal count, and emits a one-cycle tick. It supports one-shot and periodic auto-reload modes. It sits beside the event counter and supplies timebase ticks that the counter or other blocks consume as their count enable.

Parameters:
SIZE, 16, counter and reload register width.
DEFAULT_VAL, 16'h00FC, reload register value after reset.
PRESCALE, 4, enabled cycles per decrement; used only when PRESCALE_EN is defined; legal range 2..256.

Ports:
clk  input  1  rising-edge clock.
_sreset  input  1  synchronous reset, active-high.
_load  input  1  write preld_val into the reload register this cycle.
preld_val  input  SIZE  reload value.
_start  input  1  start or restart the timer.
_stop  input  1  abort and return to IDLE.
_mode  input  1  1 = periodic auto-reload, 0 = one-shot.
_enable  input  1  count enable; 0 holds dcount.
dcount  output  SIZE  current count, registered.
tick  output  1  one-cycle terminal-count pulse, registered.
busy  output  1  high in RUN.
done  output  1  high in DONE (one-shot expired).

Behaviour:
- Reset
  - One clock with _sreset=1.
  - Results: dcount=0, tick=0, busy=0, done=0, reload=DEFAULT_VAL, state=IDLE, prescaler=0.
  - Reset overrides every other input, including mid-RUN.
- Reload register
  - _load=1 captures preld_val at the clock edge, in any state.
  - The new value takes effect at the next start or auto-reload. It does not change the running dcount.
  - When _load and _start occur in the same cycle, _start uses the OLD reload value.
- States: IDLE, RUN, DONE. busy=(RUN), done=(DONE).
- IDLE
  - _start=1 with reload!=0: dcount<=reload, go to RUN.
  - _start=1 with reload==0: ignored, stay in IDLE.
- RUN, evaluated in priority order:
  1. _stop → IDLE, dcount<=0, no tick.
  2. _start → restart: dcount<=reload, no tick.
  3. _enable=1 and dcount>1 → dcount<=dcount-1.
  4. _enable=1 and dcount==1 → tick<=1. Then:
     - _mode=1 (periodic): dcount<=reload. If reload==0, go to IDLE with dcount=0 instead; tick still fires.
     - _mode=0 (one-shot): dcount<=0, go to DONE.
  5. _enable=0 → hold dcount.
- DONE
  - _stop → IDLE.
  - _start → RUN with dcount<=reload (same reload==0 rule as IDLE).
  - dcount stays 0.
- tick
  - High for exactly one cycle, the cycle after the terminal edge.
  - Never asserted in IDLE or DONE except that single cycle.
- Timing
  - Start edge is t0. With _enable held at 1, tick is registered at edge t0+N, where N = reload.
  - Periodic ticks repeat every N cycles. dcount sequence: N, N-1, …, 1, N, …
  - 0 is never shown in periodic mode.
- Arithmetic: no wrap below 1. dcount never decrements from 0.
- _mode is sampled only at the terminal edge; it may change mid-run.

Optional Feature:
PRESCALE_EN
- Defined:
  - A prescaler counts enabled cycles.
  - dcount decrements, or hits terminal, only when the prescaler reaches PRESCALE-1; the prescaler then wraps to 0.
  - The prescaler clears on reset, start, restart, stop, and auto-reload.
  - Tick period = N*PRESCALE cycles.
- Undefined: no prescaler logic; every enabled cycle is a decrement step.

Decomposition:
- Package dtimer16_pkg:
  - SIZE and DEFAULT_VAL constants.
  - State enum: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
- Sub-module dtimer16_prescale:
  - Inputs: clk, _sreset, clr, en.
  - Output: step.
  - Instantiated only under PRESCALE_EN; otherwise step=_enable.

Test Plan:
1. _sreset=1 for one cycle, then 0 → dcount=0, tick=0, busy=0, done=0. A _start then runs from 0x00FC, and tick fires 252 cycles after the start edge.
2. _load preld_val=5, _mode=0, _start, _enable=1 → dcount 5,4,3,2,1,0. tick is high one cycle as dcount reaches 0. busy then falls, done=1 and holds.
3. reload=3, _mode=1, _enable=1 for 10 cycles → dcount 3,2,1,3,2,1,3,…, with tick every 3 cycles. _load 2 mid-run → the next period is 2 cycles.
4. RUN at dcount=4, _enable=0 for 3 cycles → dcount holds 4. Then _start and _stop in the same cycle → IDLE, dcount=0, no tick.
5. reload=0 via _load, then _start → stays in IDLE, busy=0. Separately, _sreset asserted at dcount=7 in RUN → all outputs at reset values the next cycle.
6. PRESCALE_EN defined, PRESCALE=4, reload=2, _enable=1 → dcount steps every 4 cycles and tick fires 8 cycles after start.
